// File: rtl/radix4_booth_divider.sv
// Sequential signed radix-4 divider: two quotient bits per cycle against 1D/2D/3D multiples.
// Optional build macro RADIX4_DIV_ZERO_FAST_EN: a zero divisor skips iteration and resolves in one cycle.
module radix4_booth_divider #(
    parameter int unsigned N = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [N-1:0] dividend,
    input  logic [N-1:0] divisor,
    output logic         busy,
    output logic         valid,
    output logic [N-1:0] quotient,
    output logic [N-1:0] remainder,
    output logic         div_by_zero
);

    localparam int unsigned CW = $clog2(N/2 + 1);
    localparam logic [CW-1:0] LAST_CNT = CW'(N/2 - 1);

    typedef enum logic [1:0] {S_IDLE, S_ITER, S_FIX} state_t;

    state_t         r_state;
    logic [CW-1:0]  r_cnt;
    logic           r_sa;
    logic           r_sb;
    logic           r_dz;
    logic [N-1:0]   r_dvd;
    logic [N-1:0]   r_sh;
    logic [N+1:0]   r_d;
    logic [N+1:0]   r_d3;
    logic [N+1:0]   r_rem_p;
    logic [N-1:0]   r_q;
    logic           r_busy;
    logic           r_valid;
    logic [N-1:0]   r_quot;
    logic [N-1:0]   r_rem;
    logic           r_dbz;

    logic [N-1:0]   w_abs_a;
    logic [N-1:0]   w_abs_b;
    logic [N+1:0]   w_rp;
    logic [N+1:0]   w_d2;
    logic [N+1:0]   w_rnext;
    logic [1:0]     w_qd;

    // -2^(N-1) negates to itself, which reads correctly as the unsigned magnitude
    assign w_abs_a = dividend[N-1] ? -dividend : dividend;
    assign w_abs_b = divisor[N-1]  ? -divisor  : divisor;

    always_comb begin
        w_rp = (r_rem_p << 2) | {{N{1'b0}}, r_sh[N-1:N-2]};
        w_d2 = r_d << 1;
        if (w_rp >= r_d3) begin
            w_qd    = 2'd3;
            w_rnext = w_rp - r_d3;
        end else if (w_rp >= w_d2) begin
            w_qd    = 2'd2;
            w_rnext = w_rp - w_d2;
        end else if (w_rp >= r_d) begin
            w_qd    = 2'd1;
            w_rnext = w_rp - r_d;
        end else begin
            w_qd    = 2'd0;
            w_rnext = w_rp;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_sa    <= 1'b0;
            r_sb    <= 1'b0;
            r_dz    <= 1'b0;
            r_dvd   <= '0;
            r_sh    <= '0;
            r_d     <= '0;
            r_d3    <= '0;
            r_rem_p <= '0;
            r_q     <= '0;
            r_busy  <= 1'b0;
            r_valid <= 1'b0;
            r_quot  <= '0;
            r_rem   <= '0;
            r_dbz   <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_sa    <= dividend[N-1];
                        r_sb    <= divisor[N-1];
                        r_dz    <= (divisor == '0);
                        r_dvd   <= dividend;
                        r_sh    <= w_abs_a;
                        r_d     <= {2'b00, w_abs_b};
                        r_d3    <= {2'b00, w_abs_b} + {1'b0, w_abs_b, 1'b0};
                        r_rem_p <= '0;
                        r_q     <= '0;
                        r_cnt   <= LAST_CNT;
                        r_busy  <= 1'b1;
`ifdef RADIX4_DIV_ZERO_FAST_EN
                        r_state <= (divisor == '0) ? S_FIX : S_ITER;
`else
                        r_state <= S_ITER;
`endif
                    end
                end
                S_ITER: begin
                    r_rem_p <= w_rnext;
                    r_q     <= {r_q[N-3:0], w_qd};
                    r_sh    <= {r_sh[N-3:0], 2'b00};
                    if (r_cnt == '0) begin
                        r_state <= S_FIX;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                S_FIX: begin
                    if (r_dz) begin
                        r_quot <= '1;
                        r_rem  <= r_dvd;
                    end else begin
                        r_quot <= (r_sa ^ r_sb) ? -r_q : r_q;
                        r_rem  <= r_sa ? -r_rem_p[N-1:0] : r_rem_p[N-1:0];
                    end
                    r_dbz   <= r_dz;
                    r_valid <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign busy        = r_busy;
    assign valid       = r_valid;
    assign quotient    = r_quot;
    assign remainder   = r_rem;
    assign div_by_zero = r_dbz;

endmodule

// File: tb/tb_radix4_booth_divider.sv
// Directed-vector bench for radix4_booth_divider at N=8, plus a seeded signed model sweep.
module tb_radix4_booth_divider;

    localparam int unsigned N = 8;
`ifdef RADIX4_DIV_ZERO_FAST_EN
    localparam int ZLAT = 1;
`else
    localparam int ZLAT = 5;
`endif

    logic         clk;
    logic         rst;
    logic         start;
    logic [N-1:0] dividend;
    logic [N-1:0] divisor;
    logic         busy;
    logic         valid;
    logic [N-1:0] quotient;
    logic [N-1:0] remainder;
    logic         div_by_zero;

    int checks;
    int failures;

    radix4_booth_divider #(.N(N)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .valid       (valid),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // Issue one division, scramble the operand inputs after capture, and check latency and results.
    task automatic run_op(input string tag, input logic [N-1:0] a, input logic [N-1:0] b,
                          input logic [N-1:0] eq, input logic [N-1:0] er, input logic edz,
                          input int elat);
        int lat;
        @(negedge clk);
        dividend = a;
        divisor  = b;
        start    = 1'b1;
        @(posedge clk);
        #1;
        start    = 1'b0;
        dividend = ~a;
        divisor  = 8'h00;
        check({tag, "_busy"}, 32'(busy), 32'd1);
        lat = 0;
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk);
            #1;
            if (valid) begin
                lat = k;
                break;
            end
        end
        if (lat == 0) begin
            check({tag, "_timeout"}, 32'd0, 32'd1);
        end else begin
            check({tag, "_lat"}, 32'(lat), 32'(elat));
            check({tag, "_q"}, 32'(quotient), 32'(eq));
            check({tag, "_r"}, 32'(remainder), 32'(er));
            check({tag, "_dz"}, 32'(div_by_zero), 32'(edz));
            check({tag, "_bsy0"}, 32'(busy), 32'd0);
            @(posedge clk);
            #1;
            check({tag, "_pulse"}, 32'(valid), 32'd0);
        end
    endtask

    initial begin
        int nvalid;
        logic [N-1:0] ra;
        logic [N-1:0] rb;
        int ia;
        int ib;
        checks   = 0;
        failures = 0;
        rst      = 1'b0;
        start    = 1'b0;
        dividend = '0;
        divisor  = '0;
        #1;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_valid", 32'(valid), 32'd0);
        check("rst_q", 32'(quotient), 32'd0);
        check("rst_r", 32'(remainder), 32'd0);
        check("rst_dz", 32'(div_by_zero), 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;

        run_op("p_p",   8'd100, 8'd7,   8'h0E, 8'h02, 1'b0, 5);
        run_op("n_p",   8'h9C,  8'd7,   8'hF2, 8'hFE, 1'b0, 5);
        run_op("p_n",   8'd100, 8'hF9,  8'hF2, 8'h02, 1'b0, 5);
        run_op("n_n",   8'h9C,  8'hF9,  8'h0E, 8'hFE, 1'b0, 5);
        run_op("ovf",   8'h80,  8'hFF,  8'h80, 8'h00, 1'b0, 5);
        run_op("min1",  8'h80,  8'd1,   8'h80, 8'h00, 1'b0, 5);
        run_op("max",   8'd127, 8'd127, 8'h01, 8'h00, 1'b0, 5);
        run_op("zero",  8'd0,   8'hFB,  8'h00, 8'h00, 1'b0, 5);
        run_op("small", 8'd7,   8'd100, 8'h00, 8'h07, 1'b0, 5);
        run_op("m1_2",  8'hFF,  8'd2,   8'h00, 8'hFF, 1'b0, 5);
        run_op("dz",    8'd5,   8'd0,   8'hFF, 8'h05, 1'b1, ZLAT);
        run_op("dzneg", 8'hFD,  8'd0,   8'hFF, 8'hFD, 1'b1, ZLAT);
        run_op("after", 8'd9,   8'd3,   8'h03, 8'h00, 1'b0, 5);

        // start while busy is ignored; start in the valid cycle is accepted
        @(negedge clk);
        dividend = 8'd100;
        divisor  = 8'd7;
        start    = 1'b1;
        @(posedge clk);
        #1;
        start  = 1'b0;
        nvalid = 0;
        for (int k = 1; k <= 12; k++) begin
            @(posedge clk);
            #1;
            if (valid) nvalid++;
            if (k == 1) begin
                start    = 1'b1;
                dividend = 8'd50;
                divisor  = 8'd5;
            end
            if (k == 2) start = 1'b0;
            if (k == 5) begin
                check("bb_v1", 32'(valid), 32'd1);
                check("bb_q1", 32'(quotient), 32'h0E);
                check("bb_r1", 32'(remainder), 32'h02);
                start    = 1'b1;
                dividend = 8'd50;
                divisor  = 8'd5;
            end
            if (k == 6) start = 1'b0;
            if (k == 11) begin
                check("bb_v2", 32'(valid), 32'd1);
                check("bb_q2", 32'(quotient), 32'h0A);
                check("bb_r2", 32'(remainder), 32'h00);
            end
        end
        check("bb_nvalid", 32'(nvalid), 32'd2);

        // reset in the middle of a division
        @(negedge clk);
        dividend = 8'd100;
        divisor  = 8'd7;
        start    = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        check("mr_busy", 32'(busy), 32'd0);
        check("mr_valid", 32'(valid), 32'd0);
        check("mr_q", 32'(quotient), 32'd0);
        check("mr_r", 32'(remainder), 32'd0);
        check("mr_dz", 32'(div_by_zero), 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst    = 1'b1;
        nvalid = 0;
        for (int k = 0; k < 8; k++) begin
            @(posedge clk);
            #1;
            if (valid) nvalid++;
        end
        check("mr_novalid", 32'(nvalid), 32'd0);
        run_op("post", 8'd20, 8'd6, 8'h03, 8'h02, 1'b0, 5);

        // seeded sweep against the signed integer model
        for (int i = 0; i < 200; i++) begin
            ra = 8'($urandom_range(0, 255));
            rb = 8'($urandom_range(1, 255));
            if (ra == 8'h80 && rb == 8'hFF) rb = 8'h03;
            ia = int'($signed(ra));
            ib = int'($signed(rb));
            run_op("rnd", ra, rb, 8'(ia / ib), 8'(ia % ib), 1'b0, 5);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
